// File: rtl/sseg_pkg.sv
// sseg_pkg: shared segment type, blank pattern and index-width helper
package sseg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'b0000000;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sseg_scan_timer.sv
// sseg_scan_timer: per-digit refresh counter and digit index with frame_end pulse
//   clk, rstn (sync, active-low) | idx: digit being scanned | frame_end: last cycle of last digit
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 2,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic [idx_w(N_DIGITS)-1:0]    idx,
  output logic                          frame_end
);
  localparam int IW = idx_w(N_DIGITS);
  localparam int CW = idx_w(REFRESH_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wrap, last_idx;
  always_comb begin
    wrap      = cnt_q == CW'(REFRESH_CYCLES - 1);
    last_idx  = idx_q == IW'(N_DIGITS - 1);
    frame_end = wrap && last_idx;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    idx_d     = !wrap ? idx_q : last_idx ? '0 : idx_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign idx = idx_q;
endmodule

// File: rtl/sseg_scan_axi.sv
// sseg_scan_axi: AXI-Stream fed multiplexed seven-segment scanner with tear-free frame swap
//   clk, rstn (sync, active-low) | s_data/s_valid/s_ready: frame input, one pending entry
//   seg {g..a}, an one-hot digit enable: registered, inverted when ACTIVE_LOW
module sseg_scan_axi
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 2,
  parameter int REFRESH_CYCLES = 100000,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_DIGITS-1:0][6:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [6:0]               seg,
  output logic [N_DIGITS-1:0]      an
);
  localparam int                  IW      = idx_w(N_DIGITS);
  localparam seg_t                SEG_OFF = ACTIVE_LOW != 0 ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW != 0}};
  logic [IW-1:0]              idx;
  logic                       frame_end;
  logic [N_DIGITS-1:0][6:0]   pend_q, pend_d, disp_q, disp_d;
  logic                       pend_full_q, pend_full_d, s_ready_q, s_ready_d;
  seg_t                       seg_q, seg_d;
  logic [N_DIGITS-1:0]        an_q, an_d, an_on;
  logic                       xfer, load;
  sseg_scan_timer #(
    .N_DIGITS      (N_DIGITS),
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .idx      (idx),
    .frame_end(frame_end)
  );
  // s_ready_q mirrors !pend_full_q, so a transfer and a load never share an edge
  always_comb begin
    xfer        = s_valid && s_ready_q;
    load        = frame_end && pend_full_q;
    pend_d      = xfer ? s_data : pend_q;
    pend_full_d = xfer || (pend_full_q && !load);
    disp_d      = load ? pend_q : disp_q;
    s_ready_d   = !pend_full_d;
    an_on       = N_DIGITS'(1) << idx;
    seg_d       = ACTIVE_LOW != 0 ? ~disp_q[idx] : disp_q[idx];
    an_d        = ACTIVE_LOW != 0 ? ~an_on : an_on;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q      <= {N_DIGITS{SEG_BLANK}};
      disp_q      <= {N_DIGITS{SEG_BLANK}};
      pend_full_q <= 1'b0;
      s_ready_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      pend_full_q <= pend_full_d;
      s_ready_q   <= s_ready_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end
  assign s_ready = s_ready_q;
  assign seg     = seg_q;
  assign an      = an_q;
endmodule

// File: tb/tb_sseg_scan_axi.sv
// tb_sseg_scan_axi: directed and random stimulus with a frame scoreboard for sseg_scan_axi
module tb_sseg_scan_axi;
  logic            clk, rstn, s_valid, s_ready;
  logic [1:0][6:0] s_data;
  logic [6:0]      seg;
  logic [1:0]      an;
  int              e, checks, failures;
  logic [13:0]     sb[$];
  logic [13:0]     cur, obs, exp_f;
  logic [6:0]      d0, d1;
  logic [1:0]      prev_an;
  bit              have0, have1;
  sseg_scan_axi #(
    .N_DIGITS      (2),
    .REFRESH_CYCLES(4),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .seg    (seg),
    .an     (an)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic wait_until(input int n);
    while (e < n) step();
  endtask
  task automatic send(input logic [13:0] d, output int waits);
    s_valid = 1'b1;
    s_data  = d;
    waits   = 0;
    while (!s_ready && waits < 40) begin
      step();
      waits++;
    end
    if (s_ready) begin
      sb.push_back(d);
      step();
    end else check("send_timeout", 32'(s_ready), 32'd1);
    s_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rstn) begin
      cur     = '0;
      have0   = 1'b0;
      have1   = 1'b0;
      prev_an = 2'b11;
    end else if (an != 2'b11) begin
      check("an_onehot", 32'($countones(~an)), 32'd1);
      if (an != prev_an && an == 2'b10) begin
        if (have1) begin
          obs   = {d1, d0};
          exp_f = cur;
          if (sb.size() > 0 && obs === sb[0]) exp_f = sb.pop_front();
          check("frame", 32'(obs), 32'(exp_f));
          cur = exp_f;
        end
        d0    = ~seg;
        have0 = 1'b1;
        have1 = 1'b0;
      end else if (an != prev_an && an == 2'b01 && have0) begin
        d1    = ~seg;
        have1 = 1'b1;
      end
      prev_an = an;
    end
  end
  initial begin
    int          w, acc_n, budget;
    logic [13:0] d;
    bit          acc, v;
    checks = 0; failures = 0; e = 0;
    rstn = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) step();
    check("rst_an", 32'(an), 32'h3);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_ready", 32'(s_ready), 32'd0);
    rstn = 1'b1; e = 0;
    step();
    check("ready_rise", 32'(s_ready), 32'd1);
    check("idle_an", 32'(an), 32'h2);
    check("idle_seg", 32'(seg), 32'h7f);
    send({7'h06, 7'h3F}, w);
    check("ready_pending", 32'(s_ready), 32'd0);
    wait_until(8);
    check("no_early_seg", 32'(seg), 32'h7f);
    check("no_early_an", 32'(an), 32'h1);
    check("ready_after_load", 32'(s_ready), 32'd1);
    wait_until(9);
    check("d0_an", 32'(an), 32'h2);
    check("d0_seg", 32'(seg), 32'h40);
    wait_until(12);
    check("d0_hold_an", 32'(an), 32'h2);
    check("d0_hold_seg", 32'(seg), 32'h40);
    wait_until(13);
    check("d1_an", 32'(an), 32'h1);
    check("d1_seg", 32'(seg), 32'h79);
    send({7'h5B, 7'h4F}, w);
    check("a_wait", 32'(w), 32'd0);
    send({7'h66, 7'h6D}, w);
    check("bp_wait", 32'(w), 32'd2);
    check("bp_ready_low", 32'(s_ready), 32'd0);
    check("a_d0", 32'(seg), 32'h30);
    wait_until(21);
    check("a_d1", 32'(seg), 32'h24);
    wait_until(24);
    check("a_one_frame", 32'(seg), 32'h24);
    wait_until(25);
    check("b_d0", 32'(seg), 32'h12);
    wait_until(29);
    check("b_d1", 32'(seg), 32'h19);
    wait_until(31);
    send({7'h7D, 7'h07}, w);
    wait_until(33);
    check("simul_unchanged_d0", 32'(seg), 32'h12);
    wait_until(40);
    check("simul_unchanged_d1", 32'(seg), 32'h19);
    wait_until(41);
    check("c_d0", 32'(seg), 32'h78);
    wait_until(45);
    check("c_d1", 32'(seg), 32'h02);
    send({7'h06, 7'h3F}, w);
    wait_until(50);
    check("pre_rst_seg", 32'(seg), 32'h40);
    rstn = 1'b0;
    sb.delete();
    step();
    check("mid_rst_an", 32'(an), 32'h3);
    check("mid_rst_seg", 32'(seg), 32'h7f);
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    rstn = 1'b1; e = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("blank_after_rst", 32'(seg), 32'h7f);
    end
    acc_n = 0; budget = 0;
    while (acc_n < 200 && budget < 20000) begin
      d   = 14'($urandom);
      acc = 1'b0;
      while (!acc && budget < 20000) begin
        v       = 1'($urandom_range(0, 1));
        s_valid = v;
        s_data  = v ? d : 14'($urandom);
        acc     = v && s_ready;
        step();
        budget++;
      end
      if (acc) begin
        sb.push_back(d);
        acc_n++;
      end
    end
    s_valid = 1'b0;
    check("rand_accepted", 32'(acc_n), 32'd200);
    repeat (40) step();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
